// File: rtl/regfile_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_sb : 2R/1W register file with write bypass and pending scoreboard
// Revision   : 1.0
// ---------------------------------------------------------------------------
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic [AW-1:0]   writereg_addr,
  input  logic [XLEN-1:0] writedata,
  input  logic            regwrite,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_addr,
  input  logic            Moderator_in,
  output logic [NREG-1:0] pending,
  output logic [AW:0]     pend_cnt
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pending;
  logic [AW:0]     r_pend_cnt;

  logic            w_we;
  logic            w_ie;
  logic            w_inc;
  logic            w_dec;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_pend_next;

  assign w_we = regwrite & ~Moderator_in &
                ~((ZERO_REG != 0) && (writereg_addr == '0));
  assign w_ie = iss_en & ~Moderator_in &
                ~((ZERO_REG != 0) && (iss_addr == '0));

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      w_set_mask[i] = w_ie && (iss_addr == AW'(i));
      w_clr_mask[i] = w_we && (writereg_addr == AW'(i));
    end
  end

  // OR-ing the set mask last makes a new producer win over a retiring write
  assign w_pend_next = (r_pending & ~w_clr_mask) | w_set_mask;

  // Net count change: a bit only counts if it actually flips
  assign w_inc = w_ie & ~r_pending[iss_addr];
  assign w_dec = w_we & r_pending[writereg_addr] &
                 ~(w_ie && (iss_addr == writereg_addr));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      if (w_we) begin
        r_regs[writereg_addr] <= writedata;
      end
      r_pending  <= w_pend_next;
      r_pend_cnt <= r_pend_cnt + (AW+1)'(w_inc) - (AW+1)'(w_dec);
    end
  end

  always_comb begin
    if (w_we && (writereg_addr == rs1_addr)) begin
      rs1 = writedata;
    end else if ((ZERO_REG != 0) && (rs1_addr == '0)) begin
      rs1 = '0;
    end else begin
      rs1 = r_regs[rs1_addr];
    end

    if (w_we && (writereg_addr == rs2_addr)) begin
      rs2 = writedata;
    end else if ((ZERO_REG != 0) && (rs2_addr == '0)) begin
      rs2 = '0;
    end else begin
      rs2 = r_regs[rs2_addr];
    end
  end

  assign rs1_busy = r_pending[rs1_addr] & ~(w_we && (writereg_addr == rs1_addr));
  assign rs2_busy = r_pending[rs2_addr] & ~(w_we && (writereg_addr == rs2_addr));

  assign pending  = r_pending;
  assign pend_cnt = r_pend_cnt;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_sb : scoreboard bench for regfile_sb against a behavioural model
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, writereg_addr, iss_addr;
  logic [XLEN-1:0] rs1, rs2, writedata;
  logic            rs1_busy, rs2_busy, regwrite, iss_en, Moderator_in;
  logic [NREG-1:0] pending;
  logic [AW:0]     pend_cnt;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .writereg_addr(writereg_addr), .writedata(writedata), .regwrite(regwrite),
    .iss_en(iss_en), .iss_addr(iss_addr), .Moderator_in(Moderator_in),
    .pending(pending), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        b1;
    logic        b2;
    logic [31:0] pend;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;

  // Architectural model: register values and the set of outstanding producers
  logic [31:0] m_regs [NREG];
  bit          m_pend [NREG];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rs1", rs1, mon_e.rs1);
      chk("rs2", rs2, mon_e.rs2);
      chk("rs1_busy", 32'(rs1_busy), 32'(mon_e.b1));
      chk("rs2_busy", 32'(rs2_busy), 32'(mon_e.b2));
      chk("pending", pending, mon_e.pend);
      chk("pend_cnt", 32'(pend_cnt), mon_e.cnt);
    end
  end

  function automatic logic [31:0] m_read(input int a, input bit we, input int wa, input logic [31:0] wd);
    if (we && wa == a) return wd;
    if (a == 0) return 32'd0;
    return m_regs[a];
  endfunction

  // Drive one cycle; predict this cycle's outputs, then advance the model
  task automatic step(input bit r, input bit rw, input int wa, input logic [31:0] wd,
                      input bit ie, input int ia, input bit mod, input int a1, input int a2);
    exp_t e;
    bit   we, iee;
    int   n;
    @(posedge clk);
    #1;
    rst = r; regwrite = rw; writereg_addr = AW'(wa); writedata = wd;
    iss_en = ie; iss_addr = AW'(ia); Moderator_in = mod;
    rs1_addr = AW'(a1); rs2_addr = AW'(a2);
    we  = rw && !mod && (wa != 0);
    iee = ie && !mod && (ia != 0);
    if (!r) begin
      e.rs1  = m_read(a1, we, wa, wd);
      e.rs2  = m_read(a2, we, wa, wd);
      e.b1   = m_pend[a1] && !(we && wa == a1);
      e.b2   = m_pend[a2] && !(we && wa == a2);
      e.pend = '0;
      n = 0;
      for (int i = 0; i < NREG; i++) begin
        e.pend[i] = m_pend[i];
        n += m_pend[i] ? 1 : 0;
      end
      e.cnt = 32'(n);
      exp_q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (iee) m_pend[ia] = 1'b1;
    end
  endtask

  function automatic int pick_pending();
    int cand[$];
    for (int i = 1; i < NREG; i++) if (m_pend[i]) cand.push_back(i);
    if (cand.size() == 0) return $urandom_range(0, NREG-1);
    return cand[$urandom_range(0, cand.size()-1)];
  endfunction

  initial begin
    int wa, ia, a1, a2;
    rst = 1'b1; regwrite = 0; iss_en = 0; Moderator_in = 0;
    writereg_addr = '0; writedata = '0; iss_addr = '0; rs1_addr = '0; rs2_addr = '0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // Post-reset state, then bypass and array read of x5
    step(0, 0, 0, 0, 0, 0, 0, 5, 7);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 0, 0, 0, 5, 5);
    // x0 hardwired: write ignored, issue ignored
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Issue x3, busy next cycle, retire with forwarding
    step(0, 0, 0, 0, 1, 3, 0, 3, 3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 1, 3, 32'd7, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 3, 3);
    // Same-cycle issue and write to pending x4: stays pending, array updates
    step(0, 0, 0, 0, 1, 4, 0, 4, 4);
    step(0, 1, 4, 32'd9, 1, 4, 0, 4, 4);
    step(0, 0, 0, 0, 0, 0, 0, 4, 4);
    // Moderator gating, then the same update ungated
    step(0, 1, 6, 32'h55, 1, 6, 1, 6, 6);
    step(0, 0, 0, 0, 0, 0, 0, 6, 6);
    step(0, 1, 6, 32'h55, 1, 6, 0, 6, 6);
    step(0, 0, 0, 0, 0, 0, 0, 6, 6);
    // Fill every register, re-issue a pending one, then reset discards all
    for (int i = 1; i < NREG; i++) step(0, 0, 0, 0, 1, i, 0, i, 0);
    step(0, 0, 0, 0, 1, 9, 0, 31, 1);
    step(0, 0, 0, 0, 0, 0, 0, 31, 1);
    step(1, 1, 7, 32'h1234, 1, 8, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 7, 8);
    // Randomised traffic with occasional gating and mid-run resets
    for (int n = 0; n < 1500; n++) begin
      wa = ($urandom_range(0, 2) != 0) ? pick_pending() : $urandom_range(0, NREG-1);
      ia = $urandom_range(0, NREG-1);
      case ($urandom_range(0, 3))
        0: a1 = wa;
        1: a1 = ia;
        default: a1 = $urandom_range(0, NREG-1);
      endcase
      a2 = ($urandom_range(0, 1) != 0) ? pick_pending() : $urandom_range(0, NREG-1);
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) != 0, wa, $urandom,
           $urandom_range(0, 1) != 0, ia, $urandom_range(0, 7) == 0, a1, a2);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; regwrite = 0; iss_en = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
